// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the shared board SPI bus: grants one requester at a time,
// drives its active-low select and runs a byte-wide mode-0 shift engine for it.
module spi_bus_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    input  logic [8*NUM_REQ-1:0] tx_data,
    input  logic [NUM_REQ-1:0]   tx_valid,
    output logic [NUM_REQ-1:0]   tx_ready,
    output logic [7:0]           rx_data,
    output logic [NUM_REQ-1:0]   rx_valid,
    output logic [NUM_REQ-1:0]   ss_n,
    output logic                 sck,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, SETUP, HOLD, SHIFT, GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         tx_sh_q, tx_sh_d;
    logic [7:0]         rx_sh_q, rx_sh_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ss_n_q, ss_n_d;
    logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;

    logic [IW-1:0]      scan, pick;
    logic               found;
    logic               accept;
    logic [7:0]         tx_byte;

    // Search starts one past the previous owner so every waiter is served within one turn.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        scan  = rr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = (scan == IW'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    assign tx_byte = tx_data[{owner_q, 3'b000} +: 8];
    assign accept  = (state_q == HOLD) && tx_valid[owner_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        ss_n_d     = ss_n_q;
        rx_valid_d = '0;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = SETUP;
                    owner_d      = pick;
                    rr_d         = pick;
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    ss_n_d       = '1;
                    ss_n_d[pick] = 1'b0;
                    cnt_d        = '0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(CS_SETUP - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                // A byte offered in the same cycle the request drops is still sent.
                if (accept) begin
                    state_d = SHIFT;
                    tx_sh_d = tx_byte[6:0];
                    mosi_d  = tx_byte[7];
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else if (!req[owner_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    ss_n_d  = '1;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d   = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], miso};
                    end else begin
                        sck_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d             = HOLD;
                            rx_data_d           = rx_sh_q;
                            rx_valid_d[owner_q] = 1'b1;
                            mosi_d              = 1'b0;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            mosi_d  = tx_sh_q[6];
                            tx_sh_d = {tx_sh_q[5:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CW'(CS_GAP - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            owner_q    <= '0;
            rr_q       <= IW'(NUM_REQ - 1);
            gnt_q      <= '0;
            ss_n_q     <= '1;
            rx_valid_q <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            ss_n_q     <= ss_n_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign gnt      = gnt_q;
    assign ss_n     = ss_n_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);
    assign tx_ready = (state_q == HOLD) ? gnt_q : '0;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Randomized bench for spi_bus_arbiter: a driver plays the requesters, a negedge
// monitor records SCK/MOSI and feeds MISO, and a round-robin model predicts grants.
module tb_spi_bus_arbiter;
    localparam int N     = 3;
    localparam int DIV   = 4;
    localparam int SETUP = 2;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     tx_valid = '0;
    logic [8*N-1:0]   tx_data = '0;
    logic             miso = 1'b0;
    logic [N-1:0]     gnt, tx_ready, rx_valid, ss_n;
    logic [7:0]       rx_data;
    logic             sck, mosi, busy;

    int               checks = 0;
    int               errors = 0;
    int               ncyc = 0;
    int               rise_total = 0;
    logic [7:0]       mosi_hist = '0;
    logic             sck_prev = 1'b0;
    logic             loopback = 1'b0;
    logic [7:0]       miso_byte = '0;
    int               miso_base = 0;
    int               rr_model = N - 1;

    always #5 clk = ~clk;

    spi_bus_arbiter #(.NUM_REQ(N), .CLK_DIV(DIV), .CS_SETUP(SETUP), .CS_GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .ss_n(ss_n), .sck(sck), .mosi(mosi),
        .miso(miso), .busy(busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, ncyc);
        end
    endtask

    // Round-robin rule: first requesting index after the previous owner, with wrap.
    function automatic int nextGrant(input logic [N-1:0] r, input int rr);
        for (int k = 1; k <= N; k++)
            if (r[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expectResetState(input string tag);
        checkOutput({tag, "_gnt"}, gnt, 0);
        checkOutput({tag, "_ss_n"}, ss_n, {N{1'b1}});
        checkOutput({tag, "_sck"}, sck, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_tx_ready"}, tx_ready, 0);
        checkOutput({tag, "_rx_valid"}, rx_valid, 0);
        checkOutput({tag, "_rx_data"}, rx_data, 0);
        checkOutput({tag, "_mosi"}, mosi, 0);
    endtask

    // Monitor: counts cycles, captures MOSI on each SCK rise, serves MISO, checks bus invariants.
    always @(negedge clk) begin : monitor
        int k;
        ncyc++;
        if (sck && !sck_prev) begin
            rise_total++;
            mosi_hist = {mosi_hist[6:0], mosi};
        end
        sck_prev = sck;
        k = rise_total - miso_base;
        miso = loopback ? mosi : ((k >= 0 && k < 8) ? miso_byte[7-k] : 1'b0);
        checkOutput("ss_matches_gnt", {~ss_n}, {gnt});
        checkOutput("gnt_onehot0", $onehot0(gnt), 1);
        checkOutput("ready_only_owner", {tx_ready & ~gnt}, 0);
    end

    // One complete ownership: grant, nbytes transfers, release and the select gap.
    task automatic applyStimulus(input int nbytes, input bit burst, input bit drop_mid,
                                 input bit fixed, input logic [7:0] fixed_byte);
        int         g, exp_g, t, n_g, prev_acc, rise_base;
        logic [7:0] b_tx;
        logic [N-1:0] oh;
        exp_g = nextGrant(req, rr_model);
        t = 0;
        while (gnt == '0 && t < 50) begin tick(); t++; end
        checkOutput("grant_seen", {31'b0, gnt != '0}, 1);
        if (gnt == '0) return;
        g = $clog2(gnt);
        checkOutput("grant_idx", g, exp_g);
        checkOutput("busy_owned", busy, 1);
        rr_model = exp_g;
        n_g = ncyc;
        oh = '0;
        oh[g] = 1'b1;
        req = req | (N'($urandom) & ~oh);
        prev_acc = 0;
        for (int b = 0; b < nbytes; b++) begin
            b_tx = (fixed && b == 0) ? fixed_byte : 8'($urandom);
            if (!burst && b > 0) repeat ($urandom_range(0, 3)) tick();
            tx_data[8*g +: 8] = b_tx;
            tx_valid = (N'($urandom) & ~oh) | oh;
            t = 0;
            while (!tx_ready[g] && t < 100) begin tick(); t++; end
            checkOutput("ready_seen", tx_ready[g], 1);
            if (b == 0) checkOutput("setup_cycles", ncyc - n_g, SETUP);
            if (burst && b > 0) checkOutput("burst_spacing", ncyc + 1 - prev_acc, 16*DIV + 1);
            prev_acc  = ncyc + 1;
            rise_base = rise_total;
            miso_base = rise_total;
            miso_byte = 8'($urandom);
            tick();
            checkOutput("ready_low_in_shift", tx_ready[g], 0);
            tx_valid = (burst && b < nbytes - 1) ? oh : '0;
            if (drop_mid && b == nbytes - 1) begin
                repeat ($urandom_range(1, 50)) tick();
                req[g] = 1'b0;
            end
            t = 0;
            while (!rx_valid[g] && t < 200) begin tick(); t++; end
            checkOutput("byte_latency", ncyc - prev_acc, 16*DIV);
            checkOutput("rx_valid_owner", rx_valid, oh);
            checkOutput("mosi_bits", mosi_hist, b_tx);
            checkOutput("sck_rises", rise_total - rise_base, 8);
            checkOutput("rx_data", rx_data, loopback ? b_tx : miso_byte);
            checkOutput("sck_ends_low", sck, 0);
        end
        req[g] = 1'b0;
        tick();
        checkOutput("rx_valid_pulse", rx_valid, 0);
        t = 0;
        while (busy && gnt == '0 && t < 20) begin t++; tick(); end
        checkOutput("gap_cycles", t, GAP);
        checkOutput("idle_after_gap", busy, 0);
        if (req != '0) begin
            tick();
            checkOutput("regrant_after_idle", {31'b0, gnt != '0}, 1);
        end
    endtask

    initial begin
        int t;
        repeat (3) tick();
        expectResetState("reset");
        rst = 1'b0;
        tick();

        loopback = 1'b1;
        req = 3'b001;
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 8'hA5);
        loopback = 1'b0;

        req = 3'b111;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(4, 1'b1, 1'b0, 1'b0, 8'h00);
        if (req == '0) req = 3'b100;
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 8'h00);

        for (int i = 0; i < 25; i++) begin
            if (req == '0) begin
                repeat ($urandom_range(0, 3)) tick();
                req = N'($urandom_range(1, (1 << N) - 1));
            end
            applyStimulus($urandom_range(1, 3), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), 1'b0, 8'h00);
        end

        req = '0;
        tx_valid = '0;
        rst = 1'b1;
        tick();
        expectResetState("reset_again");
        rst = 1'b0;
        rr_model = N - 1;
        tick();

        req = 3'b010;
        tx_data[15:8] = 8'h3C;
        tx_valid = 3'b010;
        t = 0;
        while (!tx_ready[1] && t < 50) begin tick(); t++; end
        checkOutput("mid_ready", tx_ready[1], 1);
        repeat (20) tick();
        checkOutput("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        expectResetState("reset_mid_shift");
        tx_valid = '0;
        rr_model = N - 1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        t = 0;
        while (gnt == '0 && t < 20) begin tick(); t++; end
        checkOutput("rr_after_reset", (gnt == '0) ? 32'hFFFF_FFFF : $clog2(gnt), nextGrant(req, rr_model));
        req = '0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
